// File: rtl/ledda_ctrl.sv
// Shadow-register front end for the iCE40 LEDDA PWM block: the CPU writes a local
// register file at full speed, and a small FSM copies dirty registers into LEDDA.
module ledda_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       we,
    input  logic [3:0] addr,
    input  logic [7:0] dbw,
    output logic [7:0] dbr,
    output logic       ledd_cs,
    output logic       ledd_den,
    output logic [3:0] ledd_addr,
    output logic [7:0] ledd_dat,
    output logic       ledd_exe
);

    // Implemented LEDDA registers: 1,2,3,5,6,8,9,A,B.
    localparam logic [15:0] IMPL_MASK = 16'h0F6E;
    localparam logic [3:0]  CTRL_IDX  = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic [15:0][7:0] shadow_bus;
    logic [15:0]      dirty_reg, dirty_next;
    logic [15:0]      wr_onehot, clr_onehot;
    logic             req_reg, req_next;
    logic             auto_reg, run_reg;
    logic             wr_en, wr_impl, wr_ctrl;
    logic             any_dirty, load_out, busy;
    logic [3:0]       sel_idx;

    assign wr_en     = en & we;
    assign wr_impl   = wr_en & IMPL_MASK[addr];
    assign wr_ctrl   = wr_en & (addr == CTRL_IDX);
    assign wr_onehot = wr_impl ? (16'd1 << addr) : 16'd0;
    assign any_dirty = |dirty_reg;
    assign busy      = (state_reg != ST_IDLE);

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi = gi + 1) begin : g_shadow
            if (IMPL_MASK[gi]) begin : g_impl
                localparam logic [7:0] RST_VAL = (gi == 8) ? 8'h80 : 8'h00;
                logic [7:0] data_reg;
                always_ff @(posedge clk or negedge rst) begin
                    if (!rst) begin
                        data_reg <= RST_VAL;
                    end else if (wr_impl && (addr == 4'(gi))) begin
                        data_reg <= dbw;
                    end
                end
                assign shadow_bus[gi] = data_reg;
            end else begin : g_none
                assign shadow_bus[gi] = 8'h00;
            end
        end
    endgenerate

    // Lowest-indexed dirty register wins.
    always_comb begin
        sel_idx = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (dirty_reg[i]) begin
                sel_idx = 4'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (req_reg && any_dirty) state_next = ST_WRITE;
            ST_WRITE: state_next = ST_GAP;
            ST_GAP:   state_next = any_dirty ? ST_WRITE : ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Strobe fields are loaded on the edge entering WRITE so cs rises with the state.
    // A CPU write landing on that same edge re-sets the dirty bit (set wins).
    always_comb begin
        load_out   = (state_next == ST_WRITE);
        clr_onehot = load_out ? (16'd1 << sel_idx) : 16'd0;
        dirty_next = (dirty_reg & ~clr_onehot) | wr_onehot;
        req_next   = (req_reg & !((state_reg == ST_IDLE) && any_dirty))
                   | (wr_impl & auto_reg)
                   | (wr_ctrl & dbw[0]);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dirty_reg <= IMPL_MASK;
            req_reg   <= 1'b1;
            auto_reg  <= 1'b0;
            run_reg   <= 1'b1;
        end else begin
            dirty_reg <= dirty_next;
            req_reg   <= req_next;
            if (wr_ctrl) begin
                auto_reg <= dbw[1];
                run_reg  <= dbw[2];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ledd_cs   <= 1'b0;
            ledd_den  <= 1'b0;
            ledd_addr <= 4'd0;
            ledd_dat  <= 8'h00;
        end else begin
            ledd_cs  <= load_out;
            ledd_den <= load_out;
            if (load_out) begin
                ledd_addr <= sel_idx;
                ledd_dat  <= shadow_bus[sel_idx];
            end
        end
    end

    assign ledd_exe = run_reg;

    always_comb begin
        if (addr == CTRL_IDX) begin
            dbr = {4'b0000, auto_reg, run_reg, req_reg, busy};
        end else begin
            dbr = shadow_bus[addr];
        end
    end

endmodule

// File: doc/ledda_ctrl.md
# ledda_ctrl

Shadow-register controller for the iCE40 LEDDA PWM block that drives the RGB LEDs. The 6502 bus writes colour, brightness and blink settings into a local shadow register file at full CPU speed. A small flush state machine copies changed ("dirty") registers into the LEDDA block one at a time, using correctly framed CS/DEN strobes with a guard cycle after each write. It sits between the CPU bus decode and the LEDDA/RGBA driver primitives and replaces direct CPU access to LEDDA.

## Interface
- No parameters.
- clk  in  1  system clock, also the LEDDA clock.
- rst  in  1  asynchronous reset, active-low. Assert asynchronously, release synchronously to clk.
- en  in  1  device selected by the bus decode.
- we  in  1  write strobe. Qualified by en; a write takes effect on the clk edge.
- addr  in  4  CPU register index.
- dbw  in  8  CPU write data.
- dbr  out  8  CPU read data. Combinational from addr.
- ledd_cs  out  1  LEDDA chip select. Registered.
- ledd_den  out  1  LEDDA data enable. Registered; always equal to ledd_cs.
- ledd_addr  out  4  LEDDA register address. Registered.
- ledd_dat  out  8  LEDDA write data. Registered.
- ledd_exe  out  1  LEDDA execute (run PWM). Registered.

## Operation
- Shadow registers (CPU index = LEDDA address), with reset values:
  - 1 PWRR = 00, 2 PWRG = 00, 3 PWRB = 00
  - 5 BCRR = 00, 6 BCFR = 00
  - 8 CR0 = 80, 9 BR = 00
  - A ONR = 00, B OFR = 00
- Indices 0, 4, 7, C, D and E are unimplemented. Writes to them are ignored; reads return 00.
- Index F is CTRL:
  - Write: bit0 COMMIT (self-clearing), bit1 AUTO, bit2 RUN. Other bits ignored.
  - Read: bit0 BUSY, bit1 REQ, bit2 RUN, bit3 AUTO, bits[7:4] = 0.
  - RUN resets to 1 and drives ledd_exe directly.
- A CPU write to an implemented index stores dbw and sets that register's dirty bit. If AUTO=1, the same write also sets REQ.
- A CPU write to CTRL with bit0=1 sets REQ.
- Reset state: all 9 dirty bits set, REQ=1, AUTO=0. The power-up flush therefore programs every register.
- FSM states:
  - IDLE: if REQ and any dirty bit is set, clear REQ and go to WRITE. Otherwise stay.
  - WRITE (1 cycle):
    - Select the lowest-indexed dirty register.
    - Register cs=den=1, that address, and its shadow value onto the outputs.
    - Clear its dirty bit. If the CPU writes the same index in the same cycle, the bit stays set and the register is rewritten later.
    - Go to GAP.
  - GAP (1 cycle): cs=den=0, address and data held. Go to WRITE if any dirty bit is set, else IDLE.
- A flush continues until no dirty bits remain, including registers dirtied mid-flush.
- COMMIT during a flush sets REQ again. This is harmless: the flush already drains everything, and the next IDLE visit sees no dirty bits.
- BUSY = FSM not in IDLE.
- REQ with all dirty bits clear: REQ stays set and is consumed at the next dirty-and-IDLE condition.

## Timing
- All outputs are registered. Reset values: ledd_cs=0, ledd_den=0, ledd_addr=0, ledd_dat=00, ledd_exe=1.
- Throughput: 2 cycles per LEDDA register write. A full 9-register flush is 18 cycles.
- Write latency: a COMMIT write in cycle T puts REQ in cycle T+1 (IDLE). ledd_cs is first high in cycle T+2.
- After rst release: ledd_cs is first high in cycle 2 (cycle 1 is the IDLE decision).
  - Addresses follow the order 1, 2, 3, 5, 6, 8, 9, A, B, one every 2 cycles.
  - BUSY falls after the final GAP.
- CPU writes and reads are never stalled. The shadow file accepts one write per cycle in every FSM state.
- Async reset mid-flush immediately forces cs=den=0 and restores all reset state. The flush then restarts from scratch.
- ledd_dat always equals the shadow value sampled in the WRITE cycle. A later CPU write cannot alter data already strobed.

## Test plan
- Reset release -> 9 strobes at cycles 2, 4, …, 18 with addr 1, 2, 3, 5, 6, 8, 9, A, B; data 00 except CR0=80. BUSY=0 from cycle 20. ledd_exe=1 throughout.
- Idle, write PWRG=3C then CTRL=01 -> exactly one strobe, addr 2, dat 3C, in the 2nd cycle after the CTRL write. No other strobes.
- AUTO=1 (CTRL=02), write PWRB=FF -> one strobe, addr 3, dat FF. Then write PWRR=11 and PWRR=22 on back-to-back cycles -> final strobe on addr 1 carries 22, with at most two addr-1 strobes total.
- During a flush, write the register currently in WRITE (index 5, value AA) -> addr 5 is strobed again later with AA. BUSY stays 1 until that rewrite's GAP completes.
- Write CTRL=00 -> ledd_exe=0 next cycle, no strobe. Read CTRL -> 00. Reads of indices 0, 4, 7 and E -> 00. Writes to those indices cause no strobe.
- Assert rst during the 5th strobe of the power-up flush -> cs=0 immediately. After release, the full 9-register sequence repeats from addr 1.
